// File: rtl/lb_if.sv
// Local-bus master/slave bundle: address, write data, one-cycle strobes and read return data.
interface lb_if;
  logic [16:0] lb_addr;
  logic [31:0] lb_data;
  logic        lb_write;
  logic        lb_read;
  logic [31:0] lb_out;

  modport master (output lb_addr, lb_data, lb_write, lb_read, input lb_out);
  modport slave  (input lb_addr, lb_data, lb_write, lb_read, output lb_out);
endinterface

// File: rtl/lb_responder.sv
// Local-bus slave: registered config write strobe, 2-cycle pipelined reads (one per cycle, never stalls),
// buffer release pulse on last-word read. Optional CFG readback shadow regs under LB_CFG_READBACK_EN.
module lb_responder #(
  parameter int reg_aw = 5,
  parameter int buf_aw = 10
) (
  input  logic              lb_clk,
  input  logic              rst,
  lb_if.slave               lb,
  output logic              cfg_we,
  output logic [reg_aw-1:0] cfg_addr,
  output logic [31:0]       cfg_data,
  output logic [buf_aw-1:0] buf_addr,
  input  logic [15:0]       buf_data,
  input  logic              buf_ready,
  output logic              buf_ack
);

  localparam logic [1:0] RG_NONE = 2'd0;
  localparam logic [1:0] RG_CFG  = 2'd1;
  localparam logic [1:0] RG_BUF  = 2'd2;
  localparam logic [1:0] RG_STAT = 2'd3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [1:0]        region;
  logic              wr_hit;
  logic [31:0]       cfg_rd;
  logic [31:0]       stat_rd;
  logic              early;

  logic              cfg_we_q, cfg_we_d;
  logic [reg_aw-1:0] cfg_addr_q, cfg_addr_d;
  logic [31:0]       cfg_data_q, cfg_data_d;
  logic              s1_vld_q, s1_vld_d;
  logic [1:0]        s1_region_q, s1_region_d;
  logic              s1_last_q, s1_last_d;
  logic [31:0]       s1_snap_q, s1_snap_d;
  logic [31:0]       lb_out_q, lb_out_d;
  logic [15:0]       ack_cnt_q, ack_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       early_cnt_q, early_cnt_d;

  always_comb begin
    region = RG_NONE;
    if (lb.lb_addr[16:reg_aw] == '0)
      region = RG_CFG;
    else if (lb.lb_addr[16] && lb.lb_addr[15:14] == 2'b01)
      region = RG_BUF;
    else if (lb.lb_addr[15:12] == 4'hC)
      region = RG_STAT;
  end

  assign wr_hit   = lb.lb_write && (region == RG_CFG);
  assign buf_addr = lb.lb_addr[buf_aw-1:0];

`ifdef LB_CFG_READBACK_EN
  logic [31:0] shadow_q [2**reg_aw];
  logic [31:0] shadow_d [2**reg_aw];

  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit)
      shadow_d[lb.lb_addr[reg_aw-1:0]] = lb.lb_data;
  end

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**reg_aw; i++)
        shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Sampled before the edge that commits a same-cycle write, so reads see the old value.
  assign cfg_rd = shadow_q[lb.lb_addr[reg_aw-1:0]];
`else
  assign cfg_rd = '0;
`endif

  always_comb begin
    stat_rd = '0;
    case (lb.lb_addr[1:0])
      2'd0: stat_rd = {buf_ready, 15'b0, ack_cnt_q};
      2'd1: stat_rd = {16'b0, wr_cnt_q};
      2'd2: stat_rd = {16'b0, rd_cnt_q};
      default: stat_rd = {16'b0, early_cnt_q};
    endcase
  end

  assign buf_ack = s1_vld_q && (s1_region_q == RG_BUF) && s1_last_q && buf_ready;
  assign early   = s1_vld_q && (s1_region_q == RG_BUF) && s1_last_q && !buf_ready;

  always_comb begin
    cfg_we_d    = wr_hit;
    cfg_addr_d  = wr_hit ? lb.lb_addr[reg_aw-1:0] : cfg_addr_q;
    cfg_data_d  = wr_hit ? lb.lb_data : cfg_data_q;

    s1_vld_d    = lb.lb_read;
    s1_region_d = region;
    s1_last_d   = &lb.lb_addr[buf_aw-1:0];
    s1_snap_d   = (region == RG_CFG) ? cfg_rd : (region == RG_STAT) ? stat_rd : 32'h0;

    lb_out_d = lb_out_q;
    if (s1_vld_q) begin
      case (s1_region_q)
        RG_BUF:          lb_out_d = {{16{buf_data[15]}}, buf_data};
        RG_CFG, RG_STAT: lb_out_d = s1_snap_q;
        default:         lb_out_d = 32'h0;
      endcase
    end

    ack_cnt_d   = sat_inc(ack_cnt_q, buf_ack);
    wr_cnt_d    = sat_inc(wr_cnt_q, wr_hit);
    rd_cnt_d    = sat_inc(rd_cnt_q, lb.lb_read);
    early_cnt_d = sat_inc(early_cnt_q, early);
  end

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      s1_vld_q    <= 1'b0;
      s1_region_q <= RG_NONE;
      s1_last_q   <= 1'b0;
      s1_snap_q   <= '0;
      lb_out_q    <= '0;
      ack_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      early_cnt_q <= '0;
    end else begin
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      s1_vld_q    <= s1_vld_d;
      s1_region_q <= s1_region_d;
      s1_last_q   <= s1_last_d;
      s1_snap_q   <= s1_snap_d;
      lb_out_q    <= lb_out_d;
      ack_cnt_q   <= ack_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      early_cnt_q <= early_cnt_d;
    end
  end

  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign lb.lb_out = lb_out_q;

endmodule

// File: tb/tb_lb_responder.sv
// Scoreboard bench for lb_responder: expected read data queued at strobe time, checked 2 cycles later.
module tb_lb_responder;
  logic        lb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [9:0]  buf_addr;
  logic [15:0] buf_data = '0;
  logic        buf_ready = 1'b0;
  logic        buf_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd    = 0;
  int n_ack   = 0;
  logic [31:0] sb_q[$];

  logic rd_d1, rd_d2, ack_cand, we_cand;

  lb_if lif ();

  lb_responder #(.reg_aw(5), .buf_aw(10)) dut (
    .lb_clk(lb_clk), .rst(rst), .lb(lif.slave),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_ready(buf_ready), .buf_ack(buf_ack)
  );

  always #5 lb_clk = ~lb_clk;

  // Registered RAM model: word n holds n-512.
  always @(posedge lb_clk) buf_data <= {6'b0, buf_addr} - 16'd512;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      rd_d1 <= 1'b0; rd_d2 <= 1'b0; ack_cand <= 1'b0; we_cand <= 1'b0;
    end else begin
      rd_d1    <= lif.lb_read;
      rd_d2    <= rd_d1;
      ack_cand <= lif.lb_read && (lif.lb_addr == 17'h143FF);
      we_cand  <= lif.lb_write && (lif.lb_addr < 17'd32);
    end
  end

  always @(negedge lb_clk) begin
    if (!rst) begin
      if (rd_d2) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
        else chk("lb_out", lif.lb_out, sb_q.pop_front());
      end
      chk("buf_ack", {31'b0, buf_ack}, {31'b0, ack_cand && buf_ready});
      chk("cfg_we", {31'b0, cfg_we}, {31'b0, we_cand});
      if (buf_ack) n_ack++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge lb_clk);
      lif.lb_read = 1'b0; lif.lb_write = 1'b0;
    end
  endtask

  task automatic rd(input logic [16:0] a, input logic [31:0] exp);
    @(negedge lb_clk);
    lif.lb_addr = a; lif.lb_read = 1'b1; lif.lb_write = 1'b0;
    sb_q.push_back(exp);
    n_rd++;
  endtask

  task automatic wr(input logic [16:0] a, input logic [31:0] d);
    @(negedge lb_clk);
    lif.lb_addr = a; lif.lb_data = d; lif.lb_write = 1'b1; lif.lb_read = 1'b0;
  endtask

  task automatic wrrd(input logic [16:0] a, input logic [31:0] d, input logic [31:0] exp);
    @(negedge lb_clk);
    lif.lb_addr = a; lif.lb_data = d; lif.lb_write = 1'b1; lif.lb_read = 1'b1;
    sb_q.push_back(exp);
    n_rd++;
  endtask

  task automatic do_reset();
    @(negedge lb_clk);
    rst = 1'b1; lif.lb_read = 1'b0; lif.lb_write = 1'b0;
    sb_q.delete(); n_rd = 0;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rb;
    lif.lb_addr = '0; lif.lb_data = '0; lif.lb_write = 1'b0; lif.lb_read = 1'b0;
    repeat (3) @(negedge lb_clk);
    chk("rst_lb_out", lif.lb_out, 32'h0);
    chk("rst_cfg_we", {31'b0, cfg_we}, 32'h0);
    chk("rst_cfg_addr", {27'b0, cfg_addr}, 32'h0);
    chk("rst_cfg_data", cfg_data, 32'h0);
    chk("rst_buf_ack", {31'b0, buf_ack}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Config write and strobe contents
    wr(17'd3, 32'h1234);
    @(negedge lb_clk);
    lif.lb_write = 1'b0;
    chk("wr_cfg_we", {31'b0, cfg_we}, 32'h1);
    chk("wr_cfg_addr", {27'b0, cfg_addr}, 32'd3);
    chk("wr_cfg_data", cfg_data, 32'h1234);
    idle(1);
    chk("wr_pulse_end", {31'b0, cfg_we}, 32'h0);
`ifdef LB_CFG_READBACK_EN
    rb = 32'h1234;
`else
    rb = 32'h0;
`endif
    rd(17'd3, rb);
    rd(17'hC001, 32'd1);
    // Non-CFG writes are dropped; back-to-back CFG writes give back-to-back pulses
    wr(17'h14005, 32'hDEAD);
    wr(17'h08000, 32'hBEEF);
    wr(17'h1C010, 32'hCAFE);
    wr(17'd7, 32'h77);
    wr(17'd31, 32'h31);
    idle(1);
    chk("b2b_cfg_addr", {27'b0, cfg_addr}, 32'd31);
    chk("b2b_cfg_data", cfg_data, 32'h31);
    rd(17'h08000, 32'h0);
    rd(17'h00020, 32'h0);
    idle(2);
    rd(17'hC001, 32'd3);
    rd(17'h1C002, n_rd);
    idle(3);

    // Full buffer sweep, back to back
    buf_ready = 1'b1;
    n_ack = 0;
    for (int n = 0; n < 1024; n++) begin
      int e;
      e = n - 512;
      rd(17'h14000 + 17'(n), 32'(e));
    end
    idle(4);
    chk("sweep_ack_cnt", n_ack, 32'd1);
    chk("sweep_drain", sb_q.size(), 32'd0);

    // Early read of last word without buf_ready
    do_reset();
    buf_ready = 1'b0;
    rd(17'h143FF, 32'h1FF);
    idle(3);
    rd(17'hC003, 32'd1);
    idle(2);
    buf_ready = 1'b1;
    idle(1);
    rd(17'h143FF, 32'h1FF);
    idle(3);
    rd(17'hC000, 32'h80000001);
    rd(17'hC003, 32'd1);
    idle(3);

    // Simultaneous write and read of the same register
    wrrd(17'd5, 32'hABCD, 32'h0);
`ifdef LB_CFG_READBACK_EN
    rb = 32'hABCD;
`else
    rb = 32'h0;
`endif
    rd(17'd5, rb);
    idle(3);
    rd(17'hC001, 32'd1);
    idle(3);

    // Reset while a last-word read is in flight
    rd(17'h143FF, 32'h1FF);
    @(posedge lb_clk);
    #1;
    rst = 1'b1; lif.lb_read = 1'b0;
    sb_q.delete(); n_rd = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_lb_out", lif.lb_out, 32'h0);
    chk("mid_rst_buf_ack", {31'b0, buf_ack}, 32'h0);
    rd(17'hC000, 32'h80000000);
    rd(17'hC001, 32'h0);
    rd(17'hC002, n_rd);
    rd(17'hC003, 32'h0);
    idle(4);
    chk("final_drain", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
